// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared CDB constants and rotating-pointer arithmetic
package cdb_arbiter_pkg;
    localparam int NUM_CDB      = 2;
    localparam int CDB_IDLE_TAG = 0;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction
endpackage

// File: rtl/cdb_arbiter_rr_pick2.sv
// rr_pick2: rotating-priority search returning the first two eligible requesters
module rr_pick2 #(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  elig,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  first_oh,
    output logic [N-1:0]  second_oh,
    output logic          first_found,
    output logic          second_found
);
    int idx;

    always_comb begin
        first_oh     = '0;
        second_oh    = '0;
        first_found  = 1'b0;
        second_found = 1'b0;
        idx          = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (elig[idx] && !first_found) begin
                first_oh[idx] = 1'b1;
                first_found   = 1'b1;
            end else if (elig[idx] && !second_found) begin
                second_oh[idx] = 1'b1;
                second_found   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants up to two result requesters per cycle onto registered cdb1/cdb2 (perf counters under CDB_PERF_EN)
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int TAG_W   = 6,
    parameter  int DATA_W  = 32,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_value,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [TAG_W-1:0]          cdb1_tag,
    output logic [DATA_W-1:0]         cdb1_value,
    output logic [TAG_W-1:0]          cdb2_tag,
    output logic [DATA_W-1:0]         cdb2_value,
    output logic [PTR_W-1:0]          rr_ptr
`ifdef CDB_PERF_EN
    ,
    output logic [31:0]               perf_bcast_cnt,
    output logic [31:0]               perf_conflict_cnt
`endif
);
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
    } cdb_t;

    logic [TAG_W-1:0]  tags   [NUM_REQ];
    logic [DATA_W-1:0] values [NUM_REQ];
    logic [NUM_REQ-1:0] elig, first_oh, second_oh;
    logic first_found, second_found, grant_en, grant1, grant2;
    logic [PTR_W-1:0] first_idx, second_idx, rr_ptr_q, rr_ptr_d;
    cdb_t cdb1_q, cdb1_d, cdb2_q, cdb2_d;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign tags[g]   = req_tag[g*TAG_W +: TAG_W];
        assign values[g] = req_value[g*DATA_W +: DATA_W];
        assign elig[g]   = req_valid[g] && (tags[g] != TAG_W'(CDB_IDLE_TAG));
    end

    rr_pick2 #(.N(NUM_REQ)) u_pick (
        .elig         (elig),
        .ptr          (rr_ptr_q),
        .first_oh     (first_oh),
        .second_oh    (second_oh),
        .first_found  (first_found),
        .second_found (second_found)
    );

    always_comb begin
        first_idx  = '0;
        second_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (first_oh[i])  first_idx  = PTR_W'(i);
            if (second_oh[i]) second_idx = PTR_W'(i);
        end
        grant_en  = !reset && !flush;
        grant1    = grant_en && first_found;
        grant2    = grant_en && second_found;
        req_ready = grant_en ? (first_oh | second_oh) : '0;
        cdb1_d    = grant1 ? {tags[first_idx], values[first_idx]} : '0;
        cdb2_d    = grant2 ? {tags[second_idx], values[second_idx]} : '0;
        // Next search starts just past the last requester served this cycle
        rr_ptr_d  = grant1 ? PTR_W'(wrap_inc(32'(grant2 ? second_idx : first_idx), NUM_REQ)) : rr_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cdb1_q   <= '0;
            cdb2_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            cdb1_q   <= cdb1_d;
            cdb2_q   <= cdb2_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign cdb1_tag   = cdb1_q.tag;
    assign cdb1_value = cdb1_q.value;
    assign cdb2_tag   = cdb2_q.tag;
    assign cdb2_value = cdb2_q.value;
    assign rr_ptr     = rr_ptr_q;

`ifdef CDB_PERF_EN
    logic [31:0] bcast_cnt_q, bcast_cnt_d, conflict_cnt_q, conflict_cnt_d;
    logic [32:0] bcast_sum;
    logic [3:0]  elig_cnt;

    always_comb begin
        elig_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) elig_cnt = elig_cnt + {3'b000, elig[i]};
        bcast_sum      = {1'b0, bcast_cnt_q} + 33'(grant1) + 33'(grant2);
        bcast_cnt_d    = bcast_sum[32] ? '1 : bcast_sum[31:0];
        conflict_cnt_d = (!flush && elig_cnt > 4'(NUM_CDB) && conflict_cnt_q != '1) ? conflict_cnt_q + 32'd1 : conflict_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bcast_cnt_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            bcast_cnt_q    <= bcast_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign perf_bcast_cnt    = bcast_cnt_q;
    assign perf_conflict_cnt = conflict_cnt_q;
`endif

    // Duplicate in-flight tags would corrupt ROB/RS wakeup
    always_ff @(posedge clk) begin
        if (!reset)
            for (int i = 0; i < NUM_REQ; i++)
                for (int j = i + 1; j < NUM_REQ; j++)
                    assert (!(elig[i] && elig[j] && tags[i] == tags[j]));
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the two common data buses (cdb1, cdb2) between NUM_REQ functional-unit result ports (ALUs, branch unit, LSQ load return).
- Grants up to two requesters per cycle with rotating priority.
- Drives registered broadcasts consumed by the dispatch scheduler, reservation stations, ROB and map table.
- Tag 0 means "no broadcast" everywhere, matching the existing CDB convention.

Parameters:
NUM_REQ, 4, number of result requesters (2..8)
TAG_W, 6, ROB tag width; tag value 0 reserved as idle
DATA_W, 32, broadcast value width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush  in  1  pipeline squash (mispredict); kills pending broadcasts
req_valid  in  NUM_REQ  requester i holds a result
req_tag  in  NUM_REQ*TAG_W  ROB tag of requester i, slice i
req_value  in  NUM_REQ*DATA_W  result of requester i, slice i
req_ready  out  NUM_REQ  combinational grant; transfer when valid&ready
cdb1_tag  out  TAG_W  bus 1 tag, 0 = idle
cdb1_value  out  DATA_W  bus 1 value
cdb2_tag  out  TAG_W  bus 2 tag, 0 = idle
cdb2_value  out  DATA_W  bus 2 value
rr_ptr  out  $clog2(NUM_REQ)  current highest-priority requester (debug)

Behaviour:
- Reset (reset=1 at posedge): cdb1_tag=cdb2_tag=0, values=0, rr_ptr=0, perf counters=0. req_ready is forced to 0 while reset=1.
- Eligible requester: req_valid[i]=1 and req_tag slice != 0. Valid with tag 0 is ignored (never ready, never broadcast).
- Search order: rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - First eligible requester gets bus 1; second eligible gets bus 2.
  - At most 2 req_ready bits high per cycle.
- req_ready depends only on req_valid, req_tag, rr_ptr, flush and reset; no path from req_value.
- Latency: granted result appears on cdbN exactly 1 cycle after the handshake cycle. Outputs are registered and held only for that one cycle.
  - No bus-1 grant: cdb1_tag=0 next cycle. No bus-2 grant: cdb2_tag=0 next cycle.
  - Values are don't-care when the tag is 0, but are driven 0.
- Pointer update:
  - Any grant: rr_ptr <= (index of last granted requester + 1) mod NUM_REQ, where "last" is the bus-2 grantee if one exists, else the bus-1 grantee.
  - No grant: rr_ptr unchanged.
  - Guarantees that any continuously eligible requester is granted within ceil(NUM_REQ/2) cycles.
- Single eligible requester: gets bus 1; bus 2 is idle.
- Requester holding valid without ready must keep tag/value stable (requester's obligation). The arbiter stores no per-requester state.
- Two requesters presenting the same nonzero tag is illegal: assertion in simulation, no defined output.
- flush=1:
  - req_ready=0 for all requesters that cycle.
  - Next cycle both tags are 0, including anything that would otherwise broadcast.
  - rr_ptr unchanged.
  - Broadcast already on the bus during the flush cycle is not retracted.
- flush and reset together: reset wins (same result).

Optional Feature:
- CDB_PERF_EN.
- Defined: adds 32-bit outputs perf_bcast_cnt and perf_conflict_cnt, both saturating.
  - perf_bcast_cnt increments by the number of grants each cycle (0/1/2).
  - perf_conflict_cnt increments by 1 each cycle with more than 2 eligible requesters and flush=0.
  - Both cleared by reset.
- Undefined: ports and counters absent; all other behaviour is identical.

Decomposition:
- Shared package (existing processor typedef package):
  - cdb struct (tag, value), reused for internal bus registers.
  - CDB_IDLE_TAG = 0.
  - Constant NUM_CDB = 2.
- Sub-module rr_pick2: purely combinational. Given eligible mask and pointer, returns first/second grant one-hot plus found flags. It is the only natural split and is instantiated once.

Test Plan:
1. Reset with all 4 requesters valid (tags 1..4) -> during reset req_ready=0000. First cycle after: ready=0011, next cycle cdb1_tag=1, cdb2_tag=2, rr_ptr=2.
2. Requester 2 only, tag 5, value 0xDEADBEEF -> ready=0100; next cycle cdb1=(5,0xDEADBEEF), cdb2_tag=0, rr_ptr=3.
3. All 4 valid for 4 cycles, tags 1..4 held and re-presented after each grant -> grant pairs {0,1},{2,3},{0,1},{2,3}; no requester waits more than 2 cycles.
4. Requesters 1 and 3 valid, rr_ptr=2 -> bus1=req3, bus2=req1, rr_ptr becomes 2.
5. flush=1 with requesters 0,1 valid -> ready=0000; next cycle both tags 0; rr_ptr unchanged. Following cycle grants resume.
6. req_valid=1 with tag 0 on requester 0, requester 1 tag 7 -> only requester 1 ready, broadcast on cdb1. With CDB_PERF_EN, perf_bcast_cnt +1 and perf_conflict_cnt +0.
